// File: rtl/shift_pipe_if.sv
// Operand/result handshake bundle for shift_pipe.
// The producer/consumer side takes the master modport; the shifter takes the slave modport.
interface shift_pipe_if #(
  parameter int DPW  = 32,
  parameter int TAGW = 5
);
  localparam int AMTW = $clog2(DPW);

  logic            in_valid;
  logic            in_ready;
  logic [DPW-1:0]  in_data;
  logic [AMTW-1:0] in_amt;
  logic [2:0]      in_mode;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [DPW-1:0]  out_data;
  logic [TAGW-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with tag sideband and per-stage back-pressure.
// Left modes are bit-reversed on entry and exit so every stage only needs right-shift/rotate hardware.
module shift_pipe #(
  parameter int DPW         = 32,
  parameter int LVL_PER_STG = 2,
  parameter int TAGW        = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  shift_pipe_if.slave io_pipe
);
  localparam int NLVL = $clog2(DPW);
  localparam int NSTG = (NLVL + LVL_PER_STG - 1) / LVL_PER_STG;

  localparam logic [2:0] M_SLL = 3'b000;
  localparam logic [2:0] M_SRA = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;

  logic [NSTG-1:0] r_vld;
  logic [DPW-1:0]  r_data [NSTG];
  logic [NLVL-1:0] r_amt  [NSTG];
  logic [2:0]      r_mode [NSTG];
  logic [TAGW-1:0] r_tag  [NSTG];

  logic [NSTG-1:0] w_adv;
  logic [NSTG-1:0] w_src_vld;
  logic [DPW-1:0]  w_src_data [NSTG];
  logic [NLVL-1:0] w_src_amt  [NSTG];
  logic [2:0]      w_src_mode [NSTG];
  logic [TAGW-1:0] w_src_tag  [NSTG];
  logic [DPW-1:0]  w_nxt_data [NSTG];
  logic [NLVL-1:0] w_nxt_amt  [NSTG];

  function automatic logic [DPW-1:0] f_rev(input logic [DPW-1:0] d);
    logic [DPW-1:0] r;
    for (int b = 0; b < DPW; b++) r[b] = d[DPW-1-b];
    return r;
  endfunction

  function automatic logic f_left(input logic [2:0] m);
    return (m == M_SLL) || (m == M_ROL);
  endfunction

  // Right shift/rotate by sh; SRA fill uses the current MSB, which still equals the original sign.
  function automatic logic [DPW-1:0] f_lvl(input logic [DPW-1:0] d, input int sh,
                                           input logic [2:0] m);
    logic [DPW-1:0]   fill;
    logic [2*DPW-1:0] ext;
    case (m)
      M_SRA:        fill = {DPW{d[DPW-1]}};
      M_ROL, M_ROR: fill = d;
      default:      fill = '0;
    endcase
    ext = {fill, d} >> sh;
    return ext[DPW-1:0];
  endfunction

  always_comb begin
    logic [DPW-1:0] w_d;
    w_adv[NSTG-1] = !r_vld[NSTG-1] || io_pipe.out_ready;
    for (int k = NSTG - 2; k >= 0; k--) w_adv[k] = !r_vld[k] || w_adv[k+1];

    w_src_vld[0]  = io_pipe.in_valid;
    w_src_data[0] = f_left(io_pipe.in_mode) ? f_rev(io_pipe.in_data) : io_pipe.in_data;
    w_src_amt[0]  = io_pipe.in_amt;
    w_src_mode[0] = io_pipe.in_mode;
    w_src_tag[0]  = io_pipe.in_tag;
    for (int k = 1; k < NSTG; k++) begin
      w_src_vld[k]  = r_vld[k-1];
      w_src_data[k] = r_data[k-1];
      w_src_amt[k]  = r_amt[k-1];
      w_src_mode[k] = r_mode[k-1];
      w_src_tag[k]  = r_tag[k-1];
    end

    for (int k = 0; k < NSTG; k++) begin
      w_d = w_src_data[k];
      w_nxt_amt[k] = w_src_amt[k];
      for (int l = 0; l < NLVL; l++) begin
        if (l / LVL_PER_STG <= k) w_nxt_amt[k][l] = 1'b0;
        if ((l / LVL_PER_STG == k) && w_src_amt[k][l] && (w_src_mode[k] <= M_ROR))
          w_d = f_lvl(w_d, 1 << l, w_src_mode[k]);
      end
      if ((k == NSTG - 1) && f_left(w_src_mode[k])) w_d = f_rev(w_d);
      w_nxt_data[k] = w_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int k = 0; k < NSTG; k++) begin
        r_data[k] <= '0;
        r_amt[k]  <= '0;
        r_mode[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= w_src_vld[k];
          if (w_src_vld[k]) begin
            r_data[k] <= w_nxt_data[k];
            r_amt[k]  <= w_nxt_amt[k];
            r_mode[k] <= w_src_mode[k];
            r_tag[k]  <= w_src_tag[k];
          end
        end
      end
    end
  end

  assign io_pipe.in_ready  = w_adv[0] && !i_flush;
  assign io_pipe.out_valid = r_vld[NSTG-1];
  assign io_pipe.out_data  = r_data[NSTG-1];
  assign io_pipe.out_tag   = r_tag[NSTG-1];
endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed mode/handshake scenarios on DPW=32/LVL=2, then randomized
// traffic on three geometries checked against an arithmetic shift model and an in-order queue.
module tb_shift_pipe;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  shift_pipe_if #(.DPW(32), .TAGW(5)) if_a ();
  shift_pipe_if #(.DPW(8),  .TAGW(5)) if_b ();
  shift_pipe_if #(.DPW(64), .TAGW(5)) if_c ();

  shift_pipe #(.DPW(32), .LVL_PER_STG(2), .TAGW(5)) u_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .io_pipe(if_a));
  shift_pipe #(.DPW(8), .LVL_PER_STG(1), .TAGW(5)) u_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .io_pipe(if_b));
  shift_pipe #(.DPW(64), .LVL_PER_STG(4), .TAGW(5)) u_c (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .io_pipe(if_c));

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int          acc;
    bit          stalled;
    bit          seen;
  } item_t;

  function automatic logic [63:0] ref_shift(input int w, input logic [63:0] d, input int a,
                                            input logic [2:0] m);
    logic [63:0] mask, x, r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = d & mask;
    case (m)
      3'd0: r = (x << a) & mask;
      3'd1: r = x >> a;
      3'd2: begin
        r = x >> a;
        if (x[w-1]) r = r | (mask & ~(mask >> a));
      end
      3'd3: r = (a == 0) ? x : (((x << a) | (x >> (w - a))) & mask);
      3'd4: r = (a == 0) ? x : (((x >> a) | (x << (w - a))) & mask);
      default: r = x;
    endcase
    return r;
  endfunction

  task automatic drv(input int c, input bit v, input logic [63:0] d, input int a,
                     input logic [2:0] m, input logic [4:0] t, input bit ordy);
    case (c)
      0: begin
        if_a.in_valid = v; if_a.in_data = d[31:0]; if_a.in_amt = a[4:0];
        if_a.in_mode = m; if_a.in_tag = t; if_a.out_ready = ordy;
      end
      1: begin
        if_b.in_valid = v; if_b.in_data = d[7:0]; if_b.in_amt = a[2:0];
        if_b.in_mode = m; if_b.in_tag = t; if_b.out_ready = ordy;
      end
      default: begin
        if_c.in_valid = v; if_c.in_data = d; if_c.in_amt = a[5:0];
        if_c.in_mode = m; if_c.in_tag = t; if_c.out_ready = ordy;
      end
    endcase
  endtask

  task automatic smp(input int c, output logic irdy, output logic ov, output logic [63:0] od,
                     output logic [4:0] ot);
    case (c)
      0: begin irdy = if_a.in_ready; ov = if_a.out_valid; od = {32'h0, if_a.out_data}; ot = if_a.out_tag; end
      1: begin irdy = if_b.in_ready; ov = if_b.out_valid; od = {56'h0, if_b.out_data}; ot = if_b.out_tag; end
      default: begin irdy = if_c.in_ready; ov = if_c.out_valid; od = if_c.out_data; ot = if_c.out_tag; end
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", if_a.out_valid); end
    checks++; if (if_a.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", if_a.out_data); end
    checks++; if (if_a.out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", if_a.out_tag); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", if_a.in_ready); end
  endtask

  task automatic test_sll_srl_sra();
    logic [31:0] din [3];
    logic [4:0]  amt [3];
    logic [2:0]  md  [3];
    logic [31:0] expd[3];
    bit          ev;
    din  = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
    amt  = '{5'd31, 5'd31, 5'd4};
    md   = '{3'd0, 3'd1, 3'd2};
    expd = '{32'h8000_0000, 32'h0000_0001, 32'hF800_0000};
    for (int n = 0; n < 8; n++) begin
      if (n < 3) drv(0, 1'b1, {32'h0, din[n]}, int'(amt[n]), md[n], 5'(n + 1), 1'b1);
      else       drv(0, 1'b0, 64'd0, 0, 3'd0, 5'd0, 1'b1);
      #1;
      if (n < 3) begin
        checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL t1_in_ready n=%0d got %b want 1", n, if_a.in_ready); end
      end
      ev = (n >= 3) && (n < 6);
      checks++; if (if_a.out_valid !== ev) begin errors++; $display("FAIL t1_out_valid n=%0d got %b want %b", n, if_a.out_valid, ev); end
      if (ev) begin
        checks++; if (if_a.out_data !== expd[n-3]) begin errors++; $display("FAIL t1_data n=%0d got %h want %h", n, if_a.out_data, expd[n-3]); end
        checks++; if (if_a.out_tag !== 5'(n - 2)) begin errors++; $display("FAIL t1_tag n=%0d got %0d want %0d", n, if_a.out_tag, n - 2); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rotate_passthru();
    logic [31:0] din [9];
    logic [4:0]  amt [9];
    logic [2:0]  md  [9];
    logic [31:0] expd[9];
    din  = '{32'h8000_0001, 32'h0000_0003, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
             32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    amt  = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd13, 5'd9};
    md   = '{3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5};
    expd = '{32'h0000_0003, 32'h8000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
             32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    for (int n = 0; n < 13; n++) begin
      if (n < 9) drv(0, 1'b1, {32'h0, din[n]}, int'(amt[n]), md[n], 5'(n + 16), 1'b1);
      else       drv(0, 1'b0, 64'd0, 0, 3'd0, 5'd0, 1'b1);
      #1;
      checks++; if (if_a.out_valid !== ((n >= 3) && (n < 12))) begin errors++; $display("FAIL t2_out_valid n=%0d got %b", n, if_a.out_valid); end
      if ((n >= 3) && (n < 12)) begin
        checks++; if (if_a.out_data !== expd[n-3]) begin errors++; $display("FAIL t2_data vec=%0d got %h want %h", n - 3, if_a.out_data, expd[n-3]); end
        checks++; if (if_a.out_tag !== 5'(n + 13)) begin errors++; $display("FAIL t2_tag vec=%0d got %0d want %0d", n - 3, if_a.out_tag, n + 13); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] din [5];
    logic [31:0] expd[5];
    logic [63:0] r64;
    int acc = 0;
    int rcv = 0;
    int cur;
    for (int i = 0; i < 5; i++) begin
      din[i] = $urandom;
      r64 = ref_shift(32, {32'h0, din[i]}, i + 1, 3'd1);
      expd[i] = r64[31:0];
    end
    for (int n = 0; n < 8; n++) begin
      cur = (acc < 5) ? acc : 4;
      drv(0, 1'b1, {32'h0, din[cur]}, cur + 1, 3'd1, 5'(cur + 10), 1'b0);
      #1;
      checks++; if (if_a.in_ready !== (n < 3)) begin errors++; $display("FAIL bp_in_ready n=%0d got %b want %b", n, if_a.in_ready, n < 3); end
      if (if_a.in_ready === 1'b1) acc++;
      if (n >= 3) begin
        checks++; if (if_a.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid n=%0d got %b want 1", n, if_a.out_valid); end
        checks++; if (if_a.out_data !== expd[0]) begin errors++; $display("FAIL bp_hold_data n=%0d got %h want %h", n, if_a.out_data, expd[0]); end
        checks++; if (if_a.out_tag !== 5'd10) begin errors++; $display("FAIL bp_hold_tag n=%0d got %0d want 10", n, if_a.out_tag); end
      end
      @(posedge clk); #1;
    end
    checks++; if (acc != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", acc); end
    for (int n = 0; n < 20 && (rcv < 5 || acc < 5); n++) begin
      cur = (acc < 5) ? acc : 4;
      drv(0, acc < 5, {32'h0, din[cur]}, cur + 1, 3'd1, 5'(cur + 10), 1'b1);
      #1;
      if (n == 0) begin
        checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", if_a.in_ready); end
      end
      if (if_a.in_valid && if_a.in_ready === 1'b1) acc++;
      if (if_a.out_valid === 1'b1) begin
        if (rcv >= 5) begin
          checks++; errors++; $display("FAIL bp_extra_output tag=%0d want none", if_a.out_tag);
        end else begin
          checks++; if (if_a.out_data !== expd[rcv]) begin errors++; $display("FAIL bp_drain_data idx=%0d got %h want %h", rcv, if_a.out_data, expd[rcv]); end
          checks++; if (if_a.out_tag !== 5'(rcv + 10)) begin errors++; $display("FAIL bp_drain_tag idx=%0d got %0d want %0d", rcv, if_a.out_tag, rcv + 10); end
        end
        rcv++;
      end
      @(posedge clk); #1;
    end
    checks++; if (rcv != 5) begin errors++; $display("FAIL bp_drain_count got %0d want 5", rcv); end
    for (int n = 0; n < 4; n++) begin
      drv(0, 1'b0, 64'd0, 0, 3'd0, 5'd0, 1'b1);
      #1;
      checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup_output n=%0d tag=%0d want none", n, if_a.out_tag); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    logic [31:0] dnew;
    logic [63:0] r64;
    dnew = $urandom;
    r64 = ref_shift(32, {32'h0, dnew}, 7, 3'd4);
    for (int n = 0; n < 11; n++) begin
      flush = (n == 3);
      if (n <= 3)      drv(0, 1'b1, {32'h0, $urandom}, n + 2, 3'd1, 5'(n + 1), 1'b0);
      else if (n == 4) drv(0, 1'b1, {32'h0, dnew}, 7, 3'd4, 5'd9, 1'b1);
      else             drv(0, 1'b0, 64'd0, 0, 3'd0, 5'd0, 1'b1);
      #1;
      if (n == 3) begin
        checks++; if (if_a.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", if_a.in_ready); end
      end
      if (n >= 4) begin
        checks++; if (if_a.out_valid !== (n == 7)) begin errors++; $display("FAIL flush_out_valid n=%0d got %b tag=%0d want %b", n, if_a.out_valid, if_a.out_tag, n == 7); end
      end
      if (n == 7) begin
        checks++; if (if_a.out_tag !== 5'd9) begin errors++; $display("FAIL flush_new_tag got %0d want 9", if_a.out_tag); end
        checks++; if (if_a.out_data !== r64[31:0]) begin errors++; $display("FAIL flush_new_data got %h want %h", if_a.out_data, r64[31:0]); end
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_midstream();
    for (int n = 0; n < 4; n++) begin
      drv(0, 1'b1, {32'h0, $urandom}, n + 3, 3'd2, 5'(n + 21), 1'b0);
      #1;
      if (n == 3) begin
        checks++; if (if_a.out_valid !== 1'b1) begin errors++; $display("FAIL rstm_full_valid got %b want 1", if_a.out_valid); end
        checks++; if (if_a.in_ready !== 1'b0) begin errors++; $display("FAIL rstm_full_ready got %b want 0", if_a.in_ready); end
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drv(0, 1'b0, 64'd0, 0, 3'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL rstm_out_valid got %b want 0", if_a.out_valid); end
    checks++; if (if_a.out_data !== 32'h0) begin errors++; $display("FAIL rstm_out_data got %h want 0", if_a.out_data); end
    checks++; if (if_a.out_tag !== 5'h0) begin errors++; $display("FAIL rstm_out_tag got %h want 0", if_a.out_tag); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL rstm_in_ready got %b want 1", if_a.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int c, input int w, input int nstg);
    item_t       q[$];
    item_t       it;
    bit          v, ordy, fl, tail, known, ev;
    logic        irdy, ov;
    logic [63:0] d, od;
    logic [4:0]  t, ot;
    logic [2:0]  m;
    int          a;
    for (int n = 0; n < 400; n++) begin
      tail = (n >= 380);
      v    = !tail && ($urandom_range(0, 9) < 7);
      ordy = tail || ($urandom_range(0, 9) < 6);
      fl   = !tail && ($urandom_range(0, 39) == 0);
      d    = {$urandom, $urandom};
      a    = $urandom_range(0, w - 1);
      m    = 3'($urandom_range(0, 7));
      t    = 5'($urandom_range(0, 31));
      flush = fl;
      drv(c, v, d, a, m, t, ordy);
      #1;
      smp(c, irdy, ov, od, ot);
      checks++;
      if (irdy !== (!fl && (ordy || q.size() < nstg))) begin
        errors++; $display("FAIL rnd%0d_in_ready n=%0d got %b fill=%0d", c, n, irdy, q.size());
      end
      known = 1'b1;
      ev    = 1'b0;
      if (q.size() == 0)                  ev = 1'b0;
      else if (q[0].seen)                 ev = 1'b1;
      else if (n - q[0].acc < nstg)       ev = 1'b0;
      else if (!q[0].stalled)             ev = 1'b1;
      else                                known = 1'b0;
      if (known) begin
        checks++;
        if (ov !== ev) begin errors++; $display("FAIL rnd%0d_out_valid n=%0d got %b want %b", c, n, ov, ev); end
      end
      if (ov === 1'b1 && q.size() > 0) begin
        q[0].seen = 1'b1;
        checks++; if (od !== q[0].data) begin errors++; $display("FAIL rnd%0d_data n=%0d got %h want %h", c, n, od, q[0].data); end
        checks++; if (ot !== q[0].tag) begin errors++; $display("FAIL rnd%0d_tag n=%0d got %0d want %0d", c, n, ot, q[0].tag); end
      end
      if (fl) begin
        q.delete();
      end else begin
        if (ov === 1'b1 && ordy && q.size() > 0) void'(q.pop_front());
        if (!ordy) foreach (q[i]) q[i].stalled = 1'b1;
        if (v && irdy === 1'b1) begin
          it = '{ref_shift(w, d, a, m), t, n, 1'b0, 1'b0};
          q.push_back(it);
        end
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    drv(c, 1'b0, 64'd0, 0, 3'd0, 5'd0, 1'b1);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd%0d_undrained got %0d want 0", c, q.size()); end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    drv(0, 1'b0, 64'd0, 0, 3'd0, 5'd0, 1'b1);
    drv(1, 1'b0, 64'd0, 0, 3'd0, 5'd0, 1'b1);
    drv(2, 1'b0, 64'd0, 0, 3'd0, 5'd0, 1'b1);
    test_reset();
    test_sll_srl_sra();
    test_rotate_passthru();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random(0, 32, 3);
    test_random(1, 8, 3);
    test_random(2, 64, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
